// File: rtl/code_loader_pkg.sv
// Shared definitions for the byte-stream code loader: widths, sync marker, state encoding.
// Used by code_loader and code_loader_csum (checksum path enabled by LOADER_CHECKSUM_EN).
package code_loader_pkg;

   localparam int unsigned LD_ADDR_W = 9;
   localparam int unsigned LD_DATA_W = 16;
   localparam int unsigned LD_LEN_W  = 10;
   localparam logic [7:0]  LD_SYNC   = 8'hD1;

   typedef enum logic [3:0] {
      LD_IDLE,
      LD_LEN_HI,
      LD_LEN_LO,
      LD_DATA_HI,
      LD_DATA_LO,
      LD_WRITE,
      LD_CHECK,
      LD_RUN,
      LD_ERR
   } ld_state_t;

   // Word count carried by the frame header: two low bits of LEN_HI above LEN_LO.
   function automatic logic [LD_LEN_W-1:0] frame_len(input logic [1:0] len_hi,
                                                     input logic [7:0] len_lo);
      return {len_hi, len_lo};
   endfunction

endpackage

// File: rtl/code_loader_csum.sv
// 8-bit modular checksum accumulator with clear, add and a zero check of sum + din.
// Instantiated by code_loader only when LOADER_CHECKSUM_EN is defined.
module code_loader_csum (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clr,
   input  logic       add,
   input  logic [7:0] din,
   output logic       zero_c
);

   logic [7:0] sum_q, sum_d;

   always_comb begin
      sum_d = sum_q;
      if (clr) begin
         sum_d = 8'd0;
      end else if (add) begin
         sum_d = sum_q + din;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sum_q <= 8'd0;
      end else begin
         sum_q <= sum_d;
      end
   end

   // True when the byte currently on din would bring the running sum to zero.
   assign zero_c = ((sum_q + din) == 8'd0);

endmodule

// File: rtl/code_loader.sv
// Framed byte-stream program loader driving the code-memory write port, then raising run.
// Define LOADER_CHECKSUM_EN to require a trailing checksum byte before entering RUN.
module code_loader
   import code_loader_pkg::*;
#(
   parameter int unsigned ADDR_W    = LD_ADDR_W,
   parameter int unsigned DATA_W    = LD_DATA_W,
   parameter logic [7:0]  SYNC_BYTE = LD_SYNC
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   output logic              code_w_en,
   output logic [ADDR_W-1:0] code_addr_in,
   output logic [DATA_W-1:0] code_in,
   output logic              run,
   output logic              done,
   output logic              err
);

   localparam int unsigned MAX_WORDS = 2 ** ADDR_W;

`ifdef LOADER_CHECKSUM_EN
   localparam ld_state_t LAST_ST = LD_CHECK;
`else
   localparam ld_state_t LAST_ST = LD_RUN;
`endif

   ld_state_t             state_q, state_d;
   logic [1:0]            len_hi_q, len_hi_d;
   logic [LD_LEN_W-1:0]   n_q, n_d;
   logic [ADDR_W-1:0]     idx_q, idx_d;
   logic [DATA_W-1:0]     data_q, data_d;
   logic [ADDR_W-1:0]     addr_q, addr_d;
   logic                  ready_q, ready_d;
   logic                  w_en_q, w_en_d;
   logic                  run_q, run_d;
   logic                  done_q, done_d;
   logic                  err_q, err_d;
   logic                  accept_c;
   logic                  sync_c;
   logic [LD_LEN_W-1:0]   n_in_c;

   assign accept_c = in_valid & ready_q;
   assign sync_c   = (in_data == SYNC_BYTE);
   assign n_in_c   = frame_len(len_hi_q, in_data);

`ifdef LOADER_CHECKSUM_EN
   logic csum_clr_c, csum_add_c, csum_zero_c;

   assign csum_clr_c = accept_c && sync_c &&
                       (state_q == LD_IDLE || state_q == LD_RUN || state_q == LD_ERR);
   assign csum_add_c = accept_c &&
                       (state_q == LD_LEN_HI || state_q == LD_LEN_LO ||
                        state_q == LD_DATA_HI || state_q == LD_DATA_LO);

   code_loader_csum u_csum (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr    (csum_clr_c),
      .add    (csum_add_c),
      .din    (in_data),
      .zero_c (csum_zero_c)
   );
`endif

   // Next-state, datapath and registered-output decode.
   always_comb begin
      state_d  = state_q;
      len_hi_d = len_hi_q;
      n_d      = n_q;
      idx_d    = idx_q;
      data_d   = data_q;
      addr_d   = addr_q;

      case (state_q)
         LD_IDLE, LD_RUN, LD_ERR: begin
            if (accept_c && sync_c) begin
               state_d = LD_LEN_HI;
               idx_d   = '0;
            end
         end
         LD_LEN_HI: begin
            if (accept_c) begin
               if (in_data[7:2] != 6'd0) begin
                  state_d = LD_ERR;
               end else begin
                  len_hi_d = in_data[1:0];
                  state_d  = LD_LEN_LO;
               end
            end
         end
         LD_LEN_LO: begin
            if (accept_c) begin
               n_d = n_in_c;
               if (32'(n_in_c) > MAX_WORDS) begin
                  state_d = LD_ERR;
               end else if (n_in_c == '0) begin
                  state_d = LAST_ST;
               end else begin
                  state_d = LD_DATA_HI;
               end
            end
         end
         LD_DATA_HI: begin
            if (accept_c) begin
               data_d[DATA_W-1 -: 8] = in_data;
               state_d               = LD_DATA_LO;
            end
         end
         LD_DATA_LO: begin
            if (accept_c) begin
               data_d[7:0] = in_data;
               addr_d      = idx_q;
               state_d     = LD_WRITE;
            end
         end
         LD_WRITE: begin
            // Index stops at the last word so a full-size image never wraps.
            if (32'(idx_q) + 32'd1 == 32'(n_q)) begin
               state_d = LAST_ST;
            end else begin
               idx_d   = idx_q + ADDR_W'(1);
               state_d = LD_DATA_HI;
            end
         end
`ifdef LOADER_CHECKSUM_EN
         LD_CHECK: begin
            if (accept_c) begin
               state_d = csum_zero_c ? LD_RUN : LD_ERR;
            end
         end
`endif
         default: begin
            state_d = LD_IDLE;
         end
      endcase

      ready_d = (state_d != LD_WRITE);
      w_en_d  = (state_d == LD_WRITE);
      run_d   = (state_d == LD_RUN);
      done_d  = (state_d == LD_RUN) && (state_q != LD_RUN);
      err_d   = (state_d == LD_ERR);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= LD_IDLE;
         len_hi_q <= 2'd0;
         n_q      <= '0;
         idx_q    <= '0;
         data_q   <= '0;
         addr_q   <= '0;
         ready_q  <= 1'b0;
         w_en_q   <= 1'b0;
         run_q    <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         len_hi_q <= len_hi_d;
         n_q      <= n_d;
         idx_q    <= idx_d;
         data_q   <= data_d;
         addr_q   <= addr_d;
         ready_q  <= ready_d;
         w_en_q   <= w_en_d;
         run_q    <= run_d;
         done_q   <= done_d;
         err_q    <= err_d;
      end
   end

   assign in_ready     = ready_q;
   assign code_w_en    = w_en_q;
   assign code_addr_in = addr_q;
   assign code_in      = data_q;
   assign run          = run_q;
   assign done         = done_q;
   assign err          = err_q;

endmodule
